// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory between NUM_CORES fetch units.
// Optional macro IMEM_ARB_LOCK_EN adds a per-core lock input that pins the grant to one core.
module imem_fetch_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int INST_ADDR_WIDTH = 8,
    parameter int INST_WIDTH      = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_CORES-1:0]                 req,
    input  logic [NUM_CORES*INST_ADDR_WIDTH-1:0] req_addr,
`ifdef IMEM_ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]                 lock,
`endif
    output logic [NUM_CORES-1:0]                 gnt,
    output logic                                 imem_en,
    output logic [INST_ADDR_WIDTH-1:0]           imem_addr,
    input  logic [INST_WIDTH-1:0]                imem_rdata,
    output logic [INST_WIDTH-1:0]                inst_out,
    output logic [NUM_CORES-1:0]                 inst_valid
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

    logic [INST_ADDR_WIDTH-1:0] core_addr [NUM_CORES];

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_addr
            assign core_addr[gi] = req_addr[gi*INST_ADDR_WIDTH +: INST_ADDR_WIDTH];
        end
    endgenerate

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       imem_en_q;
    logic [INST_ADDR_WIDTH-1:0] imem_addr_q;
    logic [PTR_W-1:0]           owner_q;
    logic [NUM_CORES-1:0]       rd_valid_q;
    logic [INST_WIDTH-1:0]      inst_hold_q;

    logic [PTR_W-1:0]           cand;
    logic                       search_found;
    logic [PTR_W-1:0]           search_idx;
    logic                       sel_any;
    logic [PTR_W-1:0]           sel_idx;

    // Rotating priority search beginning at rr_ptr; index arithmetic wraps because NUM_CORES is a power of two.
    always_comb begin
        cand         = '0;
        search_found = 1'b0;
        search_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = rr_ptr_q + PTR_W'(i);
            if (!search_found && req[cand]) begin
                search_found = 1'b1;
                search_idx   = cand;
            end
        end
    end

`ifdef IMEM_ARB_LOCK_EN
    logic             lock_active_q, lock_active_d;
    logic [PTR_W-1:0] lock_owner_q, lock_owner_d;
    logic             lock_hold;

    assign lock_hold = lock_active_q && req[lock_owner_q] && lock[lock_owner_q];

    always_comb begin
        sel_any       = search_found;
        sel_idx       = search_idx;
        rr_ptr_d      = rr_ptr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        if (lock_hold) begin
            sel_any = 1'b1;
            sel_idx = lock_owner_q;
        end else begin
            // A lapsed lock falls back to normal search from the pointer left at owner+1.
            lock_active_d = 1'b0;
            if (search_found) begin
                rr_ptr_d = search_idx + PTR_W'(1);
            end
        end
        if (sel_any && lock[sel_idx]) begin
            lock_active_d = 1'b1;
            lock_owner_d  = sel_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end
`else
    always_comb begin
        sel_any  = search_found;
        sel_idx  = search_idx;
        rr_ptr_d = rr_ptr_q;
        if (search_found) begin
            rr_ptr_d = search_idx + PTR_W'(1);
        end
    end
`endif

    assign gnt = (reset_n && sel_any) ? (ONE_HOT0 << sel_idx) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            imem_en_q   <= 1'b0;
            imem_addr_q <= '0;
            owner_q     <= '0;
            rd_valid_q  <= '0;
            inst_hold_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            imem_en_q <= sel_any;
            if (sel_any) begin
                imem_addr_q <= core_addr[sel_idx];
                owner_q     <= sel_idx;
            end
            rd_valid_q  <= imem_en_q ? (ONE_HOT0 << owner_q) : '0;
            inst_hold_q <= inst_out;
        end
    end

    // Memory data arrives one cycle after imem_en, so it is forwarded directly and latched for idle cycles.
    assign inst_out   = (|rd_valid_q) ? imem_rdata : inst_hold_q;
    assign inst_valid = rd_valid_q;
    assign imem_en    = imem_en_q;
    assign imem_addr  = imem_addr_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: returns are predicted at transfer time and checked on arrival.
// Lock scenario runs only when IMEM_ARB_LOCK_EN is defined.
module tb_imem_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  addr [4];
    logic [31:0] req_addr;
    logic [3:0]  gnt;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst_out;
    logic [3:0]  inst_valid;
`ifdef IMEM_ARB_LOCK_EN
    logic [3:0]  lock = 4'b0000;
`endif

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

    imem_fetch_arbiter #(.NUM_CORES(4), .INST_ADDR_WIDTH(8), .INST_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_addr   (req_addr),
`ifdef IMEM_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt        (gnt),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [7:0] a);
        return {a ^ 8'h5A, 8'hC3, ~a, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_f(imem_addr);
    end

    typedef struct {
        int          core;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          valid_seen = 0;
    logic [3:0]  s_gnt;
    logic        s_en;
    logic [7:0]  s_addr;

    // One cycle: sample mid-cycle, score returns, record transfers, then step past the next rising edge.
    task automatic tick();
        exp_t       e;
        logic [3:0] onehot;
        @(negedge clk);
        cyc++;
        s_gnt  = gnt;
        s_en   = imem_en;
        s_addr = imem_addr;
        vectors++;
        if (($countones(gnt) > 1) || ((gnt & ~req) !== 4'b0000)) begin
            errors++;
            $display("FAIL gnt_legal: got gnt=%b with req=%b, expected at most one bit within req", gnt, req);
        end
        if (inst_valid !== 4'b0000) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: got inst_valid=%b at cycle %0d, expected 0000", inst_valid, cyc);
            end else begin
                e = sb.pop_front();
                onehot = 4'b0001;
                onehot = onehot << e.core;
                valid_seen++;
                if (inst_valid !== onehot || inst_out !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL sb_return: got valid=%b data=%h cyc=%0d, expected valid=%b data=%h cyc=%0d",
                             inst_valid, inst_out, cyc, onehot, e.data, e.due);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            vectors++;
            errors++;
            $display("FAIL missing_valid: got inst_valid=0000 at cycle %0d, expected core %0d", cyc, sb[0].core);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (reset_n && req[k] && gnt[k]) sb.push_back('{k, mem_f(addr[k]), cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req = 4'b0000;
        repeat (3) tick();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding fetches, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_g;
        reset_n = 1'b0;
        req = 4'b1111;
        addr[0] = 8'h10; addr[1] = 8'h20; addr[2] = 8'h30; addr[3] = 8'h40;
        tick();
        vectors++;
        if (s_gnt !== 4'b0000 || s_en !== 1'b0 || inst_valid !== 4'b0000 || inst_out !== 32'h0 || s_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b en=%b addr=%h valid=%b out=%h, expected all zero",
                     s_gnt, s_en, s_addr, inst_valid, inst_out);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_g = 4'b0001;
            exp_g = exp_g << (i % 4);
            vectors++;
            if (s_gnt !== exp_g) begin
                errors++;
                $display("FAIL rr_rotate: got gnt=%b at step %0d, expected %b", s_gnt, i, exp_g);
            end
            if (i > 0) begin
                vectors++;
                if (s_en !== 1'b1 || s_addr !== 8'(8'h10 * ((i - 1) % 4 + 1))) begin
                    errors++;
                    $display("FAIL rr_addr: got en=%b addr=%h at step %0d, expected en=1 addr=%h",
                             s_en, s_addr, i, 8'(8'h10 * ((i - 1) % 4 + 1)));
                end
            end
        end
        drain();
    endtask

    task automatic test_single_core();
        int v0;
        v0 = valid_seen;
        addr[2] = 8'h00;
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (s_gnt !== 4'b0100) begin
                errors++;
                $display("FAIL single_gnt: got gnt=%b at step %0d, expected 0100", s_gnt, i);
            end
            addr[2] = addr[2] + 8'h01;
        end
        drain();
        vectors++;
        if (valid_seen - v0 != 5) begin
            errors++;
            $display("FAIL single_count: got %0d returns, expected 5", valid_seen - v0);
        end
    endtask

    task automatic test_wrap_ptr();
        addr[0] = 8'hA0; addr[3] = 8'hA3;
        req = 4'b1001;
        tick();
        vectors++;
        if (s_gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got gnt=%b, expected 1000", s_gnt);
        end
        req = 4'b0001;
        tick();
        vectors++;
        if (s_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: got gnt=%b, expected 0001", s_gnt);
        end
        drain();
    endtask

    task automatic test_idle_gap();
        addr[1] = 8'h55;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        vectors++;
        if (s_gnt !== 4'b0000 || s_en !== 1'b1 || s_addr !== 8'h55) begin
            errors++;
            $display("FAIL idle_first: got gnt=%b en=%b addr=%h, expected gnt=0000 en=1 addr=55", s_gnt, s_en, s_addr);
        end
        tick();
        vectors++;
        if (s_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_en1: got en=%b, expected 0", s_en);
        end
        addr[0] = 8'h66;
        req = 4'b0001;
        tick();
        vectors++;
        if (s_en !== 1'b0 || inst_valid !== 4'b0000 || inst_out !== mem_f(8'h55) || s_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL idle_hold: got en=%b valid=%b out=%h gnt=%b, expected en=0 valid=0000 out=%h gnt=0001",
                     s_en, inst_valid, inst_out, s_gnt, mem_f(8'h55));
        end
        drain();
    endtask

    task automatic test_reset_midop();
        addr[1] = 8'h77; addr[3] = 8'h78;
        req = 4'b0010;
        tick();
        req = 4'b1010;
        vectors++;
        if (imem_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got en=%b, expected 1", imem_en);
        end
        reset_n = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if (imem_en !== 1'b0 || inst_valid !== 4'b0000 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_drop: got en=%b valid=%b gnt=%b, expected 0/0000/0000", imem_en, inst_valid, gnt);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if (s_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_first: got gnt=%b, expected 0010", s_gnt);
        end
        drain();
    endtask

`ifdef IMEM_ARB_LOCK_EN
    task automatic test_lock();
        req = 4'b0001;
        tick();
        addr[1] = 8'h90;
        req = 4'b1111;
        lock = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (s_gnt !== 4'b0010) begin
                errors++;
                $display("FAIL lock_hold: got gnt=%b at step %0d, expected 0010", s_gnt, i);
            end
        end
        lock = 4'b0000;
        tick();
        vectors++;
        if (s_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL lock_release: got gnt=%b, expected 0100", s_gnt);
        end
        drain();
    endtask
`endif

    initial begin
        addr[0] = 8'h00; addr[1] = 8'h00; addr[2] = 8'h00; addr[3] = 8'h00;
        test_reset();
        test_single_core();
        test_wrap_ptr();
        test_idle_gap();
        test_reset_midop();
`ifdef IMEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, expected completion");
        $fatal(1);
    end

endmodule
